// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion scheduler: mode codes,
// sequencer state encoding and the per-bit T-conversion rule.
package ff_conv_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  // Every mode is bitwise, so the toggle vector is this rule applied per bit.
  // SR with S=R=1 yields t=0, i.e. the bit holds.
  function automatic logic toggle_bit(input logic [1:0] mode,
                                      input logic a,
                                      input logic b,
                                      input logic q);
    logic t;
    t = 1'b0;
    case (mode)
      MODE_D:  t = a ^ q;
      MODE_T:  t = a;
      MODE_JK: t = (a & ~q) | (b & q);
      default: t = ((a & ~b) & ~q) | ((b & ~a) & q);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ff_conv_scheduler_if.sv
// Requester-side bus of the scheduler: per-requester request, mode and
// operands in, one-hot grant, bank state and SR-conflict flag out.
interface ff_conv_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     req_mode;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  err;

  modport master (
    output req, req_mode, req_a, req_b,
    input  gnt, q, err
  );

  modport slave (
    input  req, req_mode, req_a, req_b,
    output gnt, q, err
  );

endinterface

// File: rtl/ff_conv_scheduler_tff_bank.sv
// Shared bank of T flip-flops; toggles the bits set in t when en is high.
module tff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/ff_conv_scheduler.sv
// Round-robin scheduler that converts D/T/JK/SR requests into toggle vectors
// for one shared T flip-flop bank.
//   state | meaning
//   IDLE  | arbitrate pending requests, latch winner's operands, raise gnt
//   APPLY | toggle the bank, advance the round-robin pointer, report err
module ff_conv_scheduler
  import ff_conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic                clk,
  input logic                rst_n,
  ff_conv_scheduler_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_idx;
  logic [1:0]        mode_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  t_vec, bank_q;
  logic              latch, bank_en, sr_conflict;

  // Iterating from the farthest offset down leaves the nearest set bit at or
  // after ptr as the final assignment.
  always_comb begin
    win_idx = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr_q) + i) % NREQ]) begin
        win_idx = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    t_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_vec[i] = toggle_bit(mode_q, a_q[i], b_q[i], bank_q[i]);
    end
  end

  assign sr_conflict = (mode_q == MODE_SR) && (|(a_q & b_q));

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    latch   = 1'b0;
    bank_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          latch   = 1'b1;
          gnt_d   = NREQ'(1) << win_idx;
          state_d = APPLY;
        end
      end
      APPLY: begin
        bank_en = 1'b1;
        err_d   = sr_conflict;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= '0;
      mode_q <= MODE_D;
      a_q    <= '0;
      b_q    <= '0;
    end else if (latch) begin
      win_q  <= win_idx;
      mode_q <= bus.req_mode[2*int'(win_idx) +: 2];
      a_q    <= bus.req_a[WIDTH*int'(win_idx) +: WIDTH];
      b_q    <= bus.req_b[WIDTH*int'(win_idx) +: WIDTH];
    end
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bank_en),
    .t     (t_vec),
    .q     (bank_q)
  );

  assign bus.gnt = gnt_q;
  assign bus.err = err_q;
  assign bus.q   = bank_q;

endmodule

// File: tb/tb_ff_conv_scheduler.sv
// Scoreboard bench for ff_conv_scheduler: expected grant/q/err pushed per
// request, popped and compared as grants appear.
module tb_ff_conv_scheduler;
  import ff_conv_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q_before;
    logic [WIDTH-1:0] q;
    logic             err;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ff_conv_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  ff_conv_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t             sb[$];
  logic [WIDTH-1:0] model_q;
  logic [1:0]       op_mode[NREQ];
  logic [WIDTH-1:0] op_a[NREQ];
  logic [WIDTH-1:0] op_b[NREQ];
  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Characteristic-equation model: next state per bit, no toggle algebra.
  function automatic logic [WIDTH-1:0] model_next(input logic [1:0] mode,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] n;
    n = q;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        2'b00: n[i] = a[i];
        2'b01: n[i] = a[i] ? ~q[i] : q[i];
        2'b10: n[i] = (a[i] && b[i]) ? ~q[i] : (a[i] ? 1'b1 : (b[i] ? 1'b0 : q[i]));
        default: n[i] = (a[i] && !b[i]) ? 1'b1 : ((b[i] && !a[i]) ? 1'b0 : q[i]);
      endcase
    end
    return n;
  endfunction

  task automatic set_op(input int i, input logic [1:0] mode,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_mode[i] = mode;
    op_a[i]    = a;
    op_b[i]    = b;
    bus.req_mode[2*i +: 2]     = mode;
    bus.req_a[WIDTH*i +: WIDTH] = a;
    bus.req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic expect_op(input int i, input int cyc);
    exp_t e;
    e.gnt      = NREQ'(1) << i;
    e.q_before = model_q;
    model_q    = model_next(op_mode[i], op_a[i], op_b[i], model_q);
    e.q        = model_q;
    e.err      = (op_mode[i] == 2'b11) && (|(op_a[i] & op_b[i]));
    e.cyc      = cyc;
    sb.push_back(e);
  endtask

  // Services n grants; each requester releases once it sees its grant.
  task automatic serve(input int n);
    int cyc = 0;
    int got = 0;
    exp_t e;
    while (got < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk("err_idle", 32'(bus.err), 32'h0);
      if (bus.gnt != '0) begin
        if (sb.size() == 0) begin
          chk("gnt_unexpected", 32'(bus.gnt), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(e.gnt));
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("q_hold", 32'(bus.q), 32'(e.q_before));
          bus.req = bus.req & ~bus.gnt;
          @(negedge clk);
          cyc++;
          chk("q", 32'(bus.q), 32'(e.q));
          chk("err", 32'(bus.err), 32'(e.err));
          chk("gnt_low", 32'(bus.gnt), 32'h0);
        end
        got++;
      end
    end
    if (got < n) chk("grant_timeout", 32'(got), 32'(n));
    @(negedge clk);
    chk("err_pulse_end", 32'(bus.err), 32'h0);
    chk("q_stable", 32'(bus.q), 32'(model_q));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req      = '0;
    bus.req_mode = '0;
    bus.req_a    = '0;
    bus.req_b    = '0;
    model_q      = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_gnt", 32'(bus.gnt), 32'h0);

    set_op(0, MODE_D, 8'hA5, 8'h00);
    expect_op(0, 1);
    bus.req[0] = 1'b1;
    serve(1);

    set_op(1, MODE_T, 8'h0F, 8'h00);
    expect_op(1, 1);
    bus.req[1] = 1'b1;
    serve(1);

    set_op(2, MODE_JK, 8'h55, 8'hF0);
    expect_op(2, 1);
    bus.req[2] = 1'b1;
    serve(1);

    set_op(3, MODE_SR, 8'hA0, 8'h21);
    expect_op(3, 1);
    bus.req[3] = 1'b1;
    serve(1);
    chk("sr_result", 32'(bus.q), 32'hDE);

    // All four contend with ptr back at 0.
    set_op(0, MODE_D,  8'h3C, 8'h00);
    set_op(1, MODE_T,  8'hFF, 8'h00);
    set_op(2, MODE_JK, 8'hF0, 8'h0F);
    set_op(3, MODE_SR, 8'h0F, 8'hF3);
    expect_op(0, 1);
    expect_op(1, 3);
    expect_op(2, 5);
    expect_op(3, 7);
    bus.req = 4'b1111;
    serve(4);

    // Same contention, reset during the second APPLY.
    set_op(0, MODE_T, 8'h81, 8'h00);
    set_op(1, MODE_D, 8'h77, 8'h00);
    expect_op(0, 1);
    bus.req = 4'b1111;
    serve(1);
    chk("apply2_gnt", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(bus.q), 32'h0);
    chk("async_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("async_rst_err", 32'(bus.err), 32'h0);
    model_q = '0;
    #1;
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    expect_op(0, 1);
    expect_op(1, 3);
    expect_op(2, 5);
    expect_op(3, 7);
    serve(4);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
